// File: rtl/data_memory_ctrl.sv
// Data memory with valid/ready request and response ports, base + signed offset
// addressing, range checking, programmable read latency and optional zeroing after reset.
//
// state | meaning
// CLEAR | zero one word per cycle, index 0..DEPTH-1
// IDLE  | ready for a request
// WAIT  | read latency, down-counter from RD_LAT-1 to terminal count 0
// RESP  | response presented, held until rsp_ready
module data_memory_ctrl #(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 32,
  parameter int ADDR_W         = 5,
  parameter int OFF_W          = 4,
  parameter int RD_LAT         = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [DATA_W-1:0] i_req_base,
  input  logic [OFF_W-1:0]  i_req_offset,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [DATA_W-1:0]   r_ld_data;
  logic                r_ld_err;
  logic                r_req_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic signed [DATA_W:0] w_ea;
  logic                   w_in_range;
  logic [ADDR_W-1:0]      w_idx;
  logic                   w_accept;
  logic                   w_rsp_fire;
  logic                   w_mem_we;
  logic [ADDR_W-1:0]      w_mem_addr;
  logic [DATA_W-1:0]      w_mem_wdata;

  // Effective address in DATA_W+1 signed bits so a negative result is never masked.
  assign w_ea = $signed({1'b0, i_req_base}) +
                $signed({{(DATA_W+1-OFF_W){i_req_offset[OFF_W-1]}}, i_req_offset});
  assign w_in_range = !w_ea[DATA_W] && (w_ea[DATA_W-1:0] <= DATA_W'(DEPTH-1));
  assign w_idx      = w_ea[ADDR_W-1:0];
  assign w_accept   = i_req_valid && r_req_ready;
  assign w_rsp_fire = r_rsp_valid && i_rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_idx == ADDR_W'(DEPTH-1)) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_lat_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_idx;
    w_mem_wdata = i_req_wdata;
    if (r_state == S_CLEAR) begin
      w_mem_we    = i_reset_n;
      w_mem_addr  = r_clr_idx;
      w_mem_wdata = '0;
    end else if (w_accept && i_req_write && w_in_range) begin
      w_mem_we = i_reset_n;
    end
  end

  // Array has no reset; only CLEAR zeroes it.
  always_ff @(posedge i_clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      if (CLEAR_ON_RESET) r_state <= S_CLEAR;
      else                r_state <= S_IDLE;
      r_clr_idx   <= '0;
      r_lat_cnt   <= '0;
      r_ld_data   <= '0;
      r_ld_err    <= 1'b0;
      r_req_ready <= !CLEAR_ON_RESET;
      r_busy      <= CLEAR_ON_RESET;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);

      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + ADDR_W'(1);

      if (w_accept) begin
        r_lat_cnt <= LAT_W'(RD_LAT-1);
        r_ld_err  <= !w_in_range;
        r_ld_data <= (!i_req_write && w_in_range) ? r_mem[w_idx] : '0;
      end else if (r_state == S_WAIT && r_lat_cnt != '0) begin
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      end

      if (r_state == S_WAIT && w_state_nxt == S_RESP) begin
        r_rsp_rdata <= r_ld_data;
        r_rsp_err   <= r_ld_err;
      end else if (w_rsp_fire) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_busy      = r_busy;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: instance 0 clears on reset with RD_LAT=1,
// instance 1 keeps contents with RD_LAT=3; expected responses flow through a scoreboard queue.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset_n   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [15:0] req_base  [2];
  logic [3:0]  req_offset[2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [2][32];
  int          lat_cfg [2] = '{1, 3};
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.RD_LAT(1), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .i_clock(clk), .i_reset_n(reset_n[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_write(req_write[0]),
    .i_req_base(req_base[0]), .i_req_offset(req_offset[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]),
    .o_rsp_err(rsp_err[0]), .o_busy(busy[0]));

  data_memory_ctrl #(.RD_LAT(3), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .i_clock(clk), .i_reset_n(reset_n[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_write(req_write[1]),
    .i_req_base(req_base[1]), .i_req_offset(req_offset[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]),
    .o_rsp_err(rsp_err[1]), .o_busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request, wait for its response, optionally back-pressure it, and score it.
  task automatic do_req(input int d, input bit wr, input logic [15:0] base,
                        input logic [3:0] off, input logic [15:0] wd, input int hold);
    exp_t        e;
    int          ea;
    int          n;
    logic [15:0] h_d;
    logic        h_e;
    ea      = int'(base) + int'($signed(off));
    e.err   = (ea < 0) || (ea > 31);
    e.rdata = '0;
    if (!e.err) begin
      if (wr) ref_mem[d][ea] = wd;
      else    e.rdata = ref_mem[d][ea];
    end
    n = 0;
    while (!req_ready[d] && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_before", req_ready[d], 1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_base[d] = base;
    req_offset[d] = off; req_wdata[d] = wd;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    req_valid[d] = 1'b0; req_wdata[d] = 16'hA5A5; req_base[d] = 16'h0000;
    chk("req_ready_after_accept", req_ready[d], 0);
    n = 0;
    while (!rsp_valid[d] && n < 20) begin @(negedge clk); n++; end
    chk("rsp_latency", n, lat_cfg[d]);
    h_d = rsp_rdata[d];
    h_e = rsp_err[d];
    repeat (hold) begin
      @(negedge clk);
      chk("hold_rdata", rsp_rdata[d], h_d);
      chk("hold_err", rsp_err[d], h_e);
      chk("hold_valid", rsp_valid[d], 1);
      chk("hold_req_ready", req_ready[d], 0);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata[d], e.rdata);
      chk("rsp_err", rsp_err[d], e.err);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("req_ready_after_rsp", req_ready[d], 1);
    chk("rsp_valid_after_rsp", rsp_valid[d], 0);
    chk("rsp_rdata_cleared", rsp_rdata[d], 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_base[d] = '0;
      req_offset[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[d][i] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    chk("rst_a_req_ready", req_ready[0], 0);
    chk("rst_a_busy", busy[0], 1);
    chk("rst_a_rsp_valid", rsp_valid[0], 0);
    chk("rst_a_rsp_rdata", rsp_rdata[0], 0);
    chk("rst_b_req_ready", req_ready[1], 1);
    chk("rst_b_busy", busy[1], 0);
    chk("rst_b_rsp_err", rsp_err[1], 0);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;

    n = 0;
    while (!req_ready[0] && n < 100) begin @(negedge clk); n++; end
    chk("clear_cycles", n, 32);
    chk("clear_done_busy", busy[0], 0);

    // Instance 0: cleared memory, RD_LAT=1, signed offsets and bounds.
    do_req(0, 1'b0, 16'd5,     4'h0, 16'h0000, 0);
    do_req(0, 1'b1, 16'd1,     4'h0, 16'h000D, 0);
    do_req(0, 1'b0, 16'd1,     4'h0, 16'h0000, 0);
    do_req(0, 1'b1, 16'd2,     4'h0, 16'h5A5A, 0);
    do_req(0, 1'b0, 16'd3,     4'hF, 16'h0000, 0);
    do_req(0, 1'b1, 16'd0,     4'hF, 16'hDEAD, 0);
    do_req(0, 1'b1, 16'd31,    4'h1, 16'hBEEF, 1);
    do_req(0, 1'b0, 16'hFFFF,  4'h0, 16'h0000, 0);
    do_req(0, 1'b1, 16'h0020,  4'hE, 16'h00C3, 0);
    do_req(0, 1'b1, 16'h0020,  4'hF, 16'h7777, 0);
    do_req(0, 1'b0, 16'd31,    4'h0, 16'h0000, 0);
    do_req(0, 1'b0, 16'd0,     4'h0, 16'h0000, 0);
    do_req(0, 1'b0, 16'd30,    4'h0, 16'h0000, 0);
    do_req(0, 1'b0, 16'd1,     4'h7, 16'h0000, 0);

    // Instance 1: reset during WAIT after a committed store.
    n = 0;
    while (!req_ready[1] && n < 100) begin @(negedge clk); n++; end
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_base[1] = 16'd7;
    req_offset[1] = 4'h0; req_wdata[1] = 16'h1234;
    @(posedge clk);
    ref_mem[1][7] = 16'h1234;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("midrst_busy_wait", busy[1], 1);
    chk("midrst_valid_wait", rsp_valid[1], 0);
    reset_n[1] = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid[1], 0);
    chk("midrst_req_ready", req_ready[1], 1);
    chk("midrst_busy", busy[1], 0);
    reset_n[1] = 1'b1;
    @(negedge clk);
    chk("midrst_no_late_rsp", rsp_valid[1], 0);

    // Instance 1: RD_LAT=3 with back-pressure.
    do_req(1, 1'b0, 16'd7,  4'h0, 16'h0000, 4);
    do_req(1, 1'b1, 16'd9,  4'h0, 16'hCAFE, 2);
    do_req(1, 1'b0, 16'd10, 4'hF, 16'h0000, 0);
    do_req(1, 1'b0, 16'd0,  4'h8, 16'h0000, 3);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
